// File: rtl/hpdmc_datactl_seq.sv
// hpdmc_datactl_seq
// -----------------------------------------------------------------------------
// Burst data sequencer for the HPDMC DDR SDRAM controller.
// On every READ/WRITE command it steers the DQ direction, feeds 4 FML write
// words (with byte masks) to the DDR I/O stage, captures 4 returned read
// words, and tells the command scheduler when the opposite command type may
// be issued without a bus turnaround hazard.
//
// Ports
//   sys_clk, sys_rst_n : clock and synchronous active-low reset
//   read, write        : one-cycle command pulses from the scheduler
//   fml_dw, fml_sel    : write word and byte enables from the FML write buffer
//   fml_wnext          : current fml_dw/fml_sel consumed this cycle
//   fml_dr, fml_rvalid : captured read word and its valid flag
//   direction(_r)      : 1 = controller drives DQ/DQS (and 1-cycle delayed copy)
//   do_data, mo        : write word and write mask (1 = masked) to the I/O stage
//                        ("do" is a reserved word, hence do_data)
//   di                 : read word from the I/O stage
//   read_safe          : a READ may be issued this cycle
//   write_safe         : a WRITE may be issued this cycle
//   cmd_err            : sticky, set when a command had to be dropped
// All outputs are registered.
// -----------------------------------------------------------------------------
module hpdmc_datactl_seq #(
    parameter int FMLBITS  = 64,
    parameter int FMLBYTES = 8,
    parameter int CL_CYC   = 2,
    parameter int TWTR     = 2,
    parameter int TRTW     = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                read,
    input  logic                write,
    input  logic [FMLBITS-1:0]  fml_dw,
    input  logic [FMLBYTES-1:0] fml_sel,
    output logic                fml_wnext,
    output logic [FMLBITS-1:0]  fml_dr,
    output logic                fml_rvalid,
    output logic                direction,
    output logic                direction_r,
    output logic [FMLBITS-1:0]  do_data,
    output logic [FMLBYTES-1:0] mo,
    input  logic [FMLBITS-1:0]  di,
    output logic                read_safe,
    output logic                write_safe,
    output logic                cmd_err
);

    // One bit per cycle after a read command; bit 0 marks "di valid now".
    localparam int SR_W = CL_CYC + 4;
    // The four marked bits start at CL_CYC-1 because the register is loaded
    // one edge after the command, so bit k surfaces at bit 0 in cycle T+1+k.
    localparam logic [SR_W-1:0] RD_PAT  = {{(SR_W-4){1'b0}}, 4'b1111} << (CL_CYC - 1);
    localparam logic [2:0]      TWTR_LD = 3'(TWTR);
    localparam logic [2:0]      TRTW_LD = 3'(TRTW);

    logic [2:0]      wcnt_r;
    logic [2:0]      wcnt_next_s;
    logic [SR_W-1:0] rd_sr_r;
    logic [2:0]      rd_hist_r;
    logic [2:0]      twtr_cnt_r;
    logic [2:0]      trtw_cnt_r;
    logic            accept_r_s;
    logic            accept_w_s;

    // Command acceptance and next write-counter value.
    always_comb begin
        accept_r_s  = read & read_safe & (rd_hist_r == 3'b000);
        // A write coinciding with a read is always dropped. Reloading at
        // count 1 chains a second burst seamlessly behind the first.
        accept_w_s  = write & ~read & write_safe & (wcnt_r <= 3'd1);
        wcnt_next_s = 3'd0;
        if (accept_w_s) begin
            wcnt_next_s = 3'd4;
        end else if (wcnt_r != 3'd0) begin
            wcnt_next_s = wcnt_r - 3'd1;
        end else begin
            wcnt_next_s = 3'd0;
        end
    end

    // Write path: word counter, upstream handshake, DQ direction, data/mask.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wcnt_r      <= 3'd0;
            fml_wnext   <= 1'b0;
            do_data     <= {FMLBITS{1'b0}};
            mo          <= {FMLBYTES{1'b1}};
            direction   <= 1'b0;
            direction_r <= 1'b0;
        end else begin
            wcnt_r      <= wcnt_next_s;
            fml_wnext   <= (wcnt_next_s != 3'd0);
            direction_r <= direction;
            if (wcnt_r != 3'd0) begin
                do_data   <= fml_dw;
                mo        <= ~fml_sel;
                direction <= 1'b1;
            end else begin
                // do_data deliberately holds its last value between bursts.
                mo        <= {FMLBYTES{1'b1}};
                direction <= 1'b0;
            end
        end
    end

    // Read path: valid-cycle marker shift register and read-word capture.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_sr_r    <= {SR_W{1'b0}};
            rd_hist_r  <= 3'b000;
            fml_rvalid <= 1'b0;
            fml_dr     <= {FMLBITS{1'b0}};
        end else begin
            rd_sr_r    <= (rd_sr_r >> 1) | (accept_r_s ? RD_PAT : {SR_W{1'b0}});
            rd_hist_r  <= {rd_hist_r[1:0], accept_r_s};
            fml_rvalid <= rd_sr_r[0];
            if (rd_sr_r[0]) begin
                fml_dr <= di;
            end else begin
                fml_dr <= fml_dr;
            end
        end
    end

    // Write-to-read turnaround: read_safe stays low while a write burst is
    // pending and for TWTR cycles after the last driven word.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            read_safe  <= 1'b1;
            twtr_cnt_r <= 3'd0;
        end else if (accept_w_s || (wcnt_r != 3'd0)) begin
            read_safe  <= 1'b0;
            twtr_cnt_r <= TWTR_LD;
        end else if (twtr_cnt_r != 3'd0) begin
            read_safe  <= 1'b0;
            twtr_cnt_r <= twtr_cnt_r - 3'd1;
        end else begin
            read_safe  <= 1'b1;
            twtr_cnt_r <= 3'd0;
        end
    end

    // Read-to-write turnaround: write_safe stays low while read words are
    // still due and for TRTW cycles after the last fml_rvalid.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            write_safe <= 1'b1;
            trtw_cnt_r <= 3'd0;
        end else if (accept_r_s || (rd_sr_r != {SR_W{1'b0}})) begin
            write_safe <= 1'b0;
            trtw_cnt_r <= TRTW_LD;
        end else if (trtw_cnt_r != 3'd0) begin
            write_safe <= 1'b0;
            trtw_cnt_r <= trtw_cnt_r - 3'd1;
        end else begin
            write_safe <= 1'b1;
            trtw_cnt_r <= 3'd0;
        end
    end

    // Sticky protocol-violation flag for any dropped command.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_err | (read & ~accept_r_s) | (write & ~accept_w_s);
        end
    end

endmodule
